issue_window: RTL and testbench
===============================

Name: issue_window

Overview:
- 4-slot in-order issue window that feeds the post-issue-queue RAW/WAR hazard checker and consumes its per-slot issue flags.
- Presents the four oldest pending instructions (slot 1 = oldest) with valid bits; in the same cycle it takes back the flags, retires flagged slots, compacts the survivors in program order and appends one new instruction.
- Sits between the decode/rename enqueue stream and the execution dispatch ports.

Parameters:
DES_W, 4, destination register tag width
SRC1_W, 4, source-1 register tag width
SRC2_W, 4, source-2 register tag width
OP_W, 16, opaque payload width (opcode/immediate), carried untouched

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_vld  in  1  enqueue request
in_rdy  out  1  enqueue accepted when in_vld & in_rdy at posedge
in_des  in  DES_W  enqueued destination tag
in_s1  in  SRC1_W  enqueued source-1 tag
in_s2  in  SRC2_W  enqueued source-2 tag
in_op  in  OP_W  enqueued payload
slot_vld  out  4  bit n-1 = slot n valid, to checker insN_in_vld
slot_des  out  4*DES_W  slot n at bits [n*DES_W-1:(n-1)*DES_W]
slot_s1  out  4*SRC1_W  same packing
slot_s2  out  4*SRC2_W  same packing
ins_flag  in  4  bit n-1 = checker ins_flag_n for the current slots
issue_stall  in  1  downstream cannot accept; nothing retires this cycle
flush  in  1  synchronous clear of window and issue outputs
iss_vld  out  4  registered, slot n issued last cycle
iss_des  out  4*DES_W  registered issued destination tags
iss_s1  out  4*SRC1_W  registered issued source-1 tags
iss_s2  out  4*SRC2_W  registered issued source-2 tags
iss_op  out  4*OP_W  registered issued payloads
count  out  3  occupied slots, 0..4

Behaviour:
- Reset (async, rst_n low): all slot registers, slot_vld, iss_* and count = 0; in_rdy = 1 after release.
- Invariant: valid slots are contiguous from slot 1 (slot_vld is one of 0000, 0001, 0011, 0111, 1111); slot 1 holds the oldest instruction.
- slot_* outputs come straight from the slot registers (no combinational path from any input).
- Retire set per cycle: R[n] = slot_vld[n] & ins_flag[n] & ~issue_stall & ~flush. Flags on invalid slots are ignored.
- in_rdy = (count != 4). The same-cycle retire is not bypassed, so a full window never accepts, even when it drains.
- Enqueue: E = in_vld & in_rdy & ~flush.
- Next state at posedge:
  - Surviving slots (valid & ~R) shift down to the lowest positions in their original relative order.
  - The enqueued entry, if E, goes to position (count - popcount(R)).
  - count_next = count - popcount(R) + E.
- Issue outputs:
  - iss_vld <= R; for each n with R[n], iss_*[n] <= slot n contents.
  - Fields for non-issued lanes hold their previous value and are don't-care.
  - Issue latency is 1 cycle from the flag cycle; enqueue-to-visible in a slot is 1 cycle.
- Non-contiguous retire (e.g. flags 1010 with 4 valid slots) is legal; survivors keep order.
- issue_stall: no retire, iss_vld <= 0; enqueue still allowed if not full.
- flush: all slot_vld <= 0, count <= 0, iss_vld <= 0. It overrides the same-cycle enqueue and retire.
- Reset asserted mid-operation: immediate clear; any in-flight enqueue or issue is lost.
- Forward progress: the checker always flags a valid slot 1, so a non-stalled, non-empty window retires at least one slot per cycle.

Test Plan:
- Reset: rst_n low for 2 cycles, then high -> slot_vld=0000, count=0, in_rdy=1, iss_vld=0000.
- Fill: enqueue A(des=1), B(des=2), C(des=3), D(des=4) on 4 consecutive cycles with ins_flag=0000 -> slot_des order 1,2,3,4, slot_vld=1111, count=4, in_rdy=0; a 5th in_vld is held and not accepted.
- Sparse retire: full window A,B,C,D, ins_flag=0101 -> next cycle iss_vld=0101 with iss_des lane1=1, lane3=3; slots B,D; slot_vld=0011; count=2.
- Retire+enqueue: slots A,B (count=2), ins_flag=0001, enqueue E(des=5) in the same cycle -> slots B,E; count=2; iss_vld=0001 carrying A.
- Full drain, no bypass: full window, ins_flag=1111, in_vld=1 -> in_rdy=0, nothing enqueued; next cycle count=0, iss_vld=1111, in_rdy=1.
- Stall and flush: count=3, issue_stall=1, ins_flag=0111 -> count stays 3, iss_vld=0000. Next cycle flush=1 with in_vld=1 -> count=0, slot_vld=0000, iss_vld=0000.

Source files
------------

// File: rtl/issue_window.sv
// issue_window: 4-slot in-order issue window. It retires the slots the hazard checker flags,
// compacts the survivors in program order, appends one new instruction and registers the issued lanes.
module issue_window_lane #(
  parameter int DES_W  = 4,
  parameter int SRC1_W = 4,
  parameter int SRC2_W = 4,
  parameter int OP_W   = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic [DES_W-1:0]  i_des,
  input  logic [SRC1_W-1:0] i_s1,
  input  logic [SRC2_W-1:0] i_s2,
  input  logic [OP_W-1:0]   i_op,
  output logic [DES_W-1:0]  o_des,
  output logic [SRC1_W-1:0] o_s1,
  output logic [SRC2_W-1:0] o_s2,
  output logic [OP_W-1:0]   o_op
);
  // Payload of lanes that did not issue is held rather than cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_des <= '0;
      o_s1  <= '0;
      o_s2  <= '0;
      o_op  <= '0;
    end else if (i_en) begin
      o_des <= i_des;
      o_s1  <= i_s1;
      o_s2  <= i_s2;
      o_op  <= i_op;
    end
  end
endmodule

module issue_window #(
  parameter int DES_W  = 4,
  parameter int SRC1_W = 4,
  parameter int SRC2_W = 4,
  parameter int OP_W   = 16
)(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_vld,
  output logic                in_rdy,
  input  logic [DES_W-1:0]    in_des,
  input  logic [SRC1_W-1:0]   in_s1,
  input  logic [SRC2_W-1:0]   in_s2,
  input  logic [OP_W-1:0]     in_op,
  output logic [3:0]          slot_vld,
  output logic [4*DES_W-1:0]  slot_des,
  output logic [4*SRC1_W-1:0] slot_s1,
  output logic [4*SRC2_W-1:0] slot_s2,
  input  logic [3:0]          ins_flag,
  input  logic                issue_stall,
  input  logic                flush,
  output logic [3:0]          iss_vld,
  output logic [4*DES_W-1:0]  iss_des,
  output logic [4*SRC1_W-1:0] iss_s1,
  output logic [4*SRC2_W-1:0] iss_s2,
  output logic [4*OP_W-1:0]   iss_op,
  output logic [2:0]          count
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][DES_W-1:0]  r_des, w_ndes, w_iss_des;
  logic [NUM_LANES-1:0][SRC1_W-1:0] r_s1, w_ns1, w_iss_s1;
  logic [NUM_LANES-1:0][SRC2_W-1:0] r_s2, w_ns2, w_iss_s2;
  logic [NUM_LANES-1:0][OP_W-1:0]   r_op, w_nop, w_iss_op;
  logic [NUM_LANES-1:0]             r_vld, w_nvld, w_ret, w_surv, r_iss_vld;
  logic [2:0]                       r_cnt, w_ncnt;
  logic                             w_enq;

  // Readiness looks only at the registered count: a draining full window still refuses.
  assign in_rdy = (r_cnt != 3'd4);
  assign w_ret  = r_vld & ins_flag & {NUM_LANES{~issue_stall & ~flush}};
  assign w_surv = r_vld & ~w_ret;
  assign w_enq  = in_vld & in_rdy & ~flush;

  // Pack survivors downward in slot order; the running index ends at count - popcount(R).
  always_comb begin
    w_ndes = r_des;
    w_ns1  = r_s1;
    w_ns2  = r_s2;
    w_nop  = r_op;
    w_nvld = '0;
    w_ncnt = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      if (w_surv[n]) begin
        w_ndes[w_ncnt[1:0]] = r_des[n];
        w_ns1[w_ncnt[1:0]]  = r_s1[n];
        w_ns2[w_ncnt[1:0]]  = r_s2[n];
        w_nop[w_ncnt[1:0]]  = r_op[n];
        w_nvld[w_ncnt[1:0]] = 1'b1;
        w_ncnt              = w_ncnt + 3'd1;
      end
    end
    if (w_enq) begin
      w_ndes[w_ncnt[1:0]] = in_des;
      w_ns1[w_ncnt[1:0]]  = in_s1;
      w_ns2[w_ncnt[1:0]]  = in_s2;
      w_nop[w_ncnt[1:0]]  = in_op;
      w_nvld[w_ncnt[1:0]] = 1'b1;
      w_ncnt              = w_ncnt + 3'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= '0;
      r_cnt     <= '0;
      r_des     <= '0;
      r_s1      <= '0;
      r_s2      <= '0;
      r_op      <= '0;
      r_iss_vld <= '0;
    end else if (flush) begin
      r_vld     <= '0;
      r_cnt     <= '0;
      r_iss_vld <= '0;
    end else begin
      r_vld     <= w_nvld;
      r_cnt     <= w_ncnt;
      r_des     <= w_ndes;
      r_s1      <= w_ns1;
      r_s2      <= w_ns2;
      r_op      <= w_nop;
      r_iss_vld <= w_ret;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    issue_window_lane #(.DES_W(DES_W), .SRC1_W(SRC1_W), .SRC2_W(SRC2_W), .OP_W(OP_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_en  (w_ret[g]),
      .i_des (r_des[g]),
      .i_s1  (r_s1[g]),
      .i_s2  (r_s2[g]),
      .i_op  (r_op[g]),
      .o_des (w_iss_des[g]),
      .o_s1  (w_iss_s1[g]),
      .o_s2  (w_iss_s2[g]),
      .o_op  (w_iss_op[g])
    );
  end

  assign slot_vld = r_vld;
  assign slot_des = r_des;
  assign slot_s1  = r_s1;
  assign slot_s2  = r_s2;
  assign count    = r_cnt;
  assign iss_vld  = r_iss_vld;
  assign iss_des  = w_iss_des;
  assign iss_s1   = w_iss_s1;
  assign iss_s2   = w_iss_s2;
  assign iss_op   = w_iss_op;
endmodule

// File: tb/tb_issue_window.sv
// tb_issue_window: directed stimulus with a scoreboard of expected issue bundles and
// direct checks of window state; a separate monitor pops and compares the issue outputs.
module tb_issue_window;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_vld = 1'b0;
  logic        in_rdy;
  logic [3:0]  in_des = '0, in_s1 = '0, in_s2 = '0;
  logic [15:0] in_op = '0;
  logic [3:0]  slot_vld;
  logic [15:0] slot_des, slot_s1, slot_s2;
  logic [3:0]  ins_flag = '0;
  logic        issue_stall = 1'b0, flush = 1'b0;
  logic [3:0]  iss_vld;
  logic [15:0] iss_des, iss_s1, iss_s2;
  logic [63:0] iss_op;
  logic [2:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0]      vld;
    logic [3:0][3:0] des;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  issue_window dut (
    .clk(clk), .rst_n(rst_n), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_des(in_des), .in_s1(in_s1), .in_s2(in_s2), .in_op(in_op),
    .slot_vld(slot_vld), .slot_des(slot_des), .slot_s1(slot_s1), .slot_s2(slot_s2),
    .ins_flag(ins_flag), .issue_stall(issue_stall), .flush(flush),
    .iss_vld(iss_vld), .iss_des(iss_des), .iss_s1(iss_s1), .iss_s2(iss_s2),
    .iss_op(iss_op), .count(count)
  );

  // Side fields of every instruction are derived from its destination tag.
  function automatic logic [3:0] f_s1(input logic [3:0] d); return d + 4'h8; endfunction
  function automatic logic [3:0] f_s2(input logic [3:0] d); return ~d; endfunction
  function automatic logic [15:0] f_op(input logic [3:0] d); return {12'hC0D, d}; endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] v, input logic [15:0] d);
    exp_t e;
    e.vld = v;
    e.des = d;
    q.push_back(e);
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge.
  task automatic step(input logic v, input logic [3:0] d, input logic [3:0] fl,
                      input logic st, input logic fs);
    in_vld = v; in_des = d; in_s1 = f_s1(d); in_s2 = f_s2(d); in_op = f_op(d);
    ins_flag = fl; issue_stall = st; flush = fs;
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (iss_vld != 4'b0000) begin
      if (q.size() == 0) begin
        chk("iss_unexpected", {60'd0, iss_vld}, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("iss_vld", {60'd0, iss_vld}, {60'd0, e.vld});
        for (int n = 0; n < 4; n++) begin
          if (e.vld[n]) begin
            chk($sformatf("iss_des[%0d]", n), {60'd0, iss_des[n*4 +: 4]}, {60'd0, e.des[n]});
            chk($sformatf("iss_s1[%0d]", n),  {60'd0, iss_s1[n*4 +: 4]},  {60'd0, f_s1(e.des[n])});
            chk($sformatf("iss_s2[%0d]", n),  {60'd0, iss_s2[n*4 +: 4]},  {60'd0, f_s2(e.des[n])});
            chk($sformatf("iss_op[%0d]", n),  {48'd0, iss_op[n*16 +: 16]}, {48'd0, f_op(e.des[n])});
          end
        end
      end
    end
  end

  initial begin
    // Reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_slot_vld", {60'd0, slot_vld}, 64'h0);
    chk("rst_count",    {61'd0, count},    64'h0);
    chk("rst_in_rdy",   {63'd0, in_rdy},   64'h1);
    chk("rst_iss_vld",  {60'd0, iss_vld},  64'h0);
    @(negedge clk);

    // Fill A..D, then a 5th request is refused
    step(1, 4'd1, 4'b0000, 0, 0);
    chk("fill1_des", {48'd0, slot_des}, 64'h0001);
    step(1, 4'd2, 4'b0000, 0, 0);
    step(1, 4'd3, 4'b0000, 0, 0);
    step(1, 4'd4, 4'b0000, 0, 0);
    chk("fill_des",    {48'd0, slot_des}, 64'h4321);
    chk("fill_s1",     {48'd0, slot_s1},  64'hCBA9);
    chk("fill_vld",    {60'd0, slot_vld}, 64'hF);
    chk("fill_count",  {61'd0, count},    64'd4);
    chk("fill_in_rdy", {63'd0, in_rdy},   64'd0);
    step(1, 4'd9, 4'b0000, 0, 0);
    chk("full_hold_des",   {48'd0, slot_des}, 64'h4321);
    chk("full_hold_count", {61'd0, count},    64'd4);

    // Sparse retire 0101 -> A,C issue; B,D survive
    push_exp(4'b0101, 16'h0301);
    step(0, 4'd0, 4'b0101, 0, 0);
    chk("sparse_vld",   {60'd0, slot_vld},      64'h3);
    chk("sparse_des",   {56'd0, slot_des[7:0]}, 64'h42);
    chk("sparse_count", {61'd0, count},         64'd2);

    // Retire oldest and enqueue E in the same cycle -> D,E
    push_exp(4'b0001, 16'h0002);
    step(1, 4'd5, 4'b0001, 0, 0);
    chk("renq_vld",   {60'd0, slot_vld},      64'h3);
    chk("renq_des",   {56'd0, slot_des[7:0]}, 64'h54);
    chk("renq_count", {61'd0, count},         64'd2);

    // Refill, then full drain with a simultaneous request that must be refused
    step(1, 4'd6, 4'b0000, 0, 0);
    step(1, 4'd7, 4'b0000, 0, 0);
    chk("refill_des", {48'd0, slot_des}, 64'h7654);
    chk("drain_rdy_before", {63'd0, in_rdy}, 64'd0);
    push_exp(4'b1111, 16'h7654);
    step(1, 4'd8, 4'b1111, 0, 0);
    chk("drain_count", {61'd0, count},    64'd0);
    chk("drain_vld",   {60'd0, slot_vld}, 64'h0);
    chk("drain_rdy",   {63'd0, in_rdy},   64'd1);

    // Stall holds everything, then flush wipes including the same-cycle enqueue
    step(1, 4'd1, 4'b0000, 0, 0);
    step(1, 4'd2, 4'b0000, 0, 0);
    step(1, 4'd3, 4'b0000, 0, 0);
    step(0, 4'd0, 4'b0111, 1, 0);
    chk("stall_count",   {61'd0, count},          64'd3);
    chk("stall_des",     {52'd0, slot_des[11:0]}, 64'h321);
    chk("stall_iss_vld", {60'd0, iss_vld},        64'h0);
    step(1, 4'd9, 4'b0111, 0, 1);
    chk("flush_count",   {61'd0, count},    64'd0);
    chk("flush_vld",     {60'd0, slot_vld}, 64'h0);
    chk("flush_iss_vld", {60'd0, iss_vld},  64'h0);

    // Flags on invalid slots are ignored
    step(1, 4'hA, 4'b0000, 0, 0);
    step(0, 4'd0, 4'b1110, 0, 0);
    chk("inv_flag_count", {61'd0, count},         64'd1);
    chk("inv_flag_des",   {60'd0, slot_des[3:0]}, 64'hA);
    push_exp(4'b0001, 16'h000A);
    step(0, 4'd0, 4'b1111, 0, 0);
    chk("last_count", {61'd0, count}, 64'd0);

    // Asynchronous reset mid-cycle clears immediately
    step(1, 4'd5, 4'b0000, 0, 0);
    step(1, 4'd6, 4'b0000, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", {61'd0, count},    64'd0);
    chk("arst_vld",   {60'd0, slot_vld}, 64'h0);
    in_vld = 1'b0; ins_flag = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    chk("scoreboard_empty", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
